ysyx_22050854_wb_arbiter: RTL
=============================

Name: ysyx_22050854_wb_arbiter

Overview:
Shares the register file's single write port between NREQ writeback sources (EXU, LSU, MDU) with round-robin arbitration. Each source uses a valid/ready handshake. Writes are registered toward the register file. A per-register busy scoreboard tells the decode stage when a source register still awaits a writeback (RAW hazard), so decode can stall.

Parameters:
NREQ, 3, number of writeback requesters (2..4)
XLEN, 64, data width
NREG, 32, architectural register count (index width 5)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-source writeback request
req_ready  out  NREQ  per-source grant; handshake completes when valid&ready
req_rd  in  NREQ*5  per-source destination index, packed with source i at [5i+:5]
req_data  in  NREQ*XLEN  per-source write data, packed
rf_wen  out  1  register file write enable
rf_waddr  out  5  register file write index
rf_wdata  out  XLEN  register file write data
iss_valid  in  1  decode issues an instruction that writes iss_rd
iss_rd  in  5  destination register of the issuing instruction
rs1  in  5  decode source index A
rs2  in  5  decode source index B
hazard  out  1  rs1 or rs2 is busy; decode must stall
fwd1_valid  out  1  rs1 value is available on fwd1_data (bypass)
fwd1_data  out  XLEN  bypassed rs1 value
fwd2_valid  out  1  rs2 value is available on fwd2_data
fwd2_data  out  XLEN  bypassed rs2 value

Behaviour:
- Reset (async, reset_n=0): rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=NREQ-1, all busy bits 0. Consequences: hazard=0, fwd*_valid=0, req_ready=0.
- Arbitration (combinational):
  - Among asserted req_valid, grant the first index after rr_ptr, searching cyclically.
  - Exactly one req_ready is high when any valid is present; otherwise none.
  - req_ready never depends on the same source's data.
  - The write stage always accepts, so there is no back-pressure beyond losing arbitration.
- On a handshake with source g:
  - next cycle: rf_wen=1, rf_waddr=req_rd[g], rf_wdata=req_data[g]; rr_ptr<=g.
  - With no handshake, next cycle rf_wen=0 and rr_ptr holds.
  - Latency from handshake to rf_wen is 1 cycle.
- rd==0: the handshake completes normally, rr_ptr advances, rf_wen stays 0, and the busy bit is untouched.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - A handshake for rd clears busy[rd] at the same edge.
  - Simultaneous set and clear of the same index: the set wins (a new producer is outstanding).
  - Issuing to an already-busy rd is illegal; decode must stall on hazard first. The bench checks this with an assertion.
- Hazard: hazard = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]), evaluated combinationally from current busy state.
- Starvation bound: a source held valid is granted within NREQ cycles.
- Reset mid-operation: all in-flight state is discarded. Sources must re-present requests after reset_n rises.

Optional Feature:
WB_ARB_BYPASS_EN
- Defined:
  - fwdN_valid=1 when rsN!=0 and the source register matches the current handshake's rd (granted req_rd, not 0).
  - fwdN_data carries that granted req_data.
  - hazard excludes any source satisfied by fwdN_valid. This saves one stall cycle per dependency.
- Undefined: fwd*_valid tied 0, fwd*_data tied 0, and hazard is as specified above.

Decomposition:
- Package ysyx_22050854_wb_pkg holds:
  - the localparams NREQ_MAX=4, REG_IDX_W=5, XLEN=64;
  - a packed struct wb_req_t {rd, data};
  - a function rr_next(valid, ptr) returning a one-hot grant.
- One sub-module is natural: ysyx_22050854_rr_arbiter, a generic NREQ round-robin grant plus pointer, reusable for a future memory-bus arbiter.
- The scoreboard stays inline.

Test Plan:
- Reset then single request: src0 requests x5 with data 0xDEAD_BEEF. Expect ready0 in the same cycle, then rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle later; all outputs are 0 during reset.
- Contention: all three sources valid continuously, with rd 1, 2, 3. Expect grants in order 0,1,2,0,1,2 and rf_waddr sequence 1,2,3,1,2,3, with no source waiting more than 3 cycles.
- Scoreboard: issue rd=7, then rs1=7. Expect hazard=1 until the LSU handshake for x7; hazard=0 the next cycle (same cycle if WB_ARB_BYPASS_EN, where fwd1_valid=1 and fwd1_data=LSU data).
- Simultaneous events: iss_rd=9 and a handshake for rd=9 in the same cycle. Expect busy[9]=1 afterwards and hazard=1 for rs2=9.
- x0 handling: issue rd=0 and request rd=0 with data 0x1234. Expect rf_wen=0, the rr pointer advances, and hazard=0 for rs1=0.
- Async reset mid-stream: drop reset_n between clock edges while busy[4]=1 and rf_wen=1. Expect rf_wen=0 and hazard=0 immediately, and grants restart from source 0.

Source files
------------

// File: rtl/ysyx_22050854_wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its round-robin core.
package ysyx_22050854_wb_pkg;

  localparam int NREQ_MAX  = 4;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 64;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  // One-hot grant: first asserted valid after ptr, searching cyclically over n entries.
  function automatic logic [NREQ_MAX-1:0] rr_next(input logic [NREQ_MAX-1:0] valid,
                                                  input logic [1:0] ptr,
                                                  input int n);
    logic [NREQ_MAX-1:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && g == '0 && valid[idx[1:0]]) g[idx[1:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/ysyx_22050854_wb_arbiter_if.sv
// Writeback request, register-file write and decode-hazard signals of the arbiter.
interface ysyx_22050854_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
);
  import ysyx_22050854_wb_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*REG_IDX_W-1:0] req_rd;
  logic [NREQ*XLEN-1:0]      req_data;
  logic                      rf_wen;
  logic [REG_IDX_W-1:0]      rf_waddr;
  logic [XLEN-1:0]           rf_wdata;
  logic                      iss_valid;
  logic [REG_IDX_W-1:0]      iss_rd;
  logic [REG_IDX_W-1:0]      rs1;
  logic [REG_IDX_W-1:0]      rs2;
  logic                      hazard;
  logic                      fwd1_valid;
  logic [XLEN-1:0]           fwd1_data;
  logic                      fwd2_valid;
  logic [XLEN-1:0]           fwd2_data;

  modport master (
    output req_valid, req_rd, req_data, iss_valid, iss_rd, rs1, rs2,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, hazard,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );

  modport slave (
    input  req_valid, req_rd, req_data, iss_valid, iss_rd, rs1, rs2,
    output req_ready, rf_wen, rf_waddr, rf_wdata, hazard,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );
endinterface

// File: rtl/ysyx_22050854_rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant plus last-winner pointer.
module ysyx_22050854_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic [1:0]   grant_idx
);
  import ysyx_22050854_wb_pkg::*;

  logic [1:0]          ptr;
  logic [NREQ_MAX-1:0] valid_ext;
  logic [NREQ_MAX-1:0] grant_full;
  logic                unused_grant_hi;

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
    grant_full       = rr_next(valid_ext, ptr, N);
    // Held in reset, nobody is granted even if a source is already presenting.
    grant            = reset_n ? grant_full[N-1:0] : '0;
    grant_idx        = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  assign unused_grant_hi = ^grant_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    ptr <= 2'(N - 1);
    else if (|grant) ptr <= grant_idx;
  end

endmodule

// File: rtl/ysyx_22050854_wb_arbiter.sv
// Round-robin writeback arbiter with per-register busy scoreboard.
// Optional macro WB_ARB_BYPASS_EN forwards the granted write to decode sources.
module ysyx_22050854_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic clock,
  input logic reset_n,
  ysyx_22050854_wb_arbiter_if.slave bus
);
  import ysyx_22050854_wb_pkg::*;

  logic [NREQ-1:0]      grant;
  logic [1:0]           gidx;
  logic                 hs_p0;
  wb_req_t              sel_p0;
  logic                 wen_p1;
  logic [REG_IDX_W-1:0] waddr_p1;
  logic [XLEN-1:0]      wdata_p1;
  logic [NREG-1:0]      busy;
  logic [NREG-1:0]      busy_nxt;
  logic                 dep1;
  logic                 dep2;

  ysyx_22050854_rr_arbiter #(.N(NREQ)) u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (bus.req_valid),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Stage p0: arbitration and selection of the winning source.
  assign bus.req_ready = grant;
  assign hs_p0         = |grant;

  always_comb begin
    sel_p0.rd   = bus.req_rd[REG_IDX_W*int'(gidx) +: REG_IDX_W];
    sel_p0.data = bus.req_data[XLEN*int'(gidx) +: XLEN];
  end

  // Stage p1: registered register-file write; x0 handshakes complete without a write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      wen_p1 <= hs_p0 && (sel_p0.rd != '0);
      if (hs_p0) begin
        waddr_p1 <= sel_p0.rd;
        wdata_p1 <= sel_p0.data;
      end
    end
  end

  assign bus.rf_wen   = wen_p1;
  assign bus.rf_waddr = waddr_p1;
  assign bus.rf_wdata = wdata_p1;

  // Set after clear so a fresh producer issued on the retiring edge stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (hs_p0 && sel_p0.rd != '0)      busy_nxt[sel_p0.rd]  = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0) busy_nxt[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  assign dep1 = (bus.rs1 != '0) && busy[bus.rs1];
  assign dep2 = (bus.rs2 != '0) && busy[bus.rs2];

`ifdef WB_ARB_BYPASS_EN
  always_comb begin
    bus.fwd1_valid = hs_p0 && (sel_p0.rd != '0) && (bus.rs1 == sel_p0.rd);
    bus.fwd2_valid = hs_p0 && (sel_p0.rd != '0) && (bus.rs2 == sel_p0.rd);
    bus.fwd1_data  = bus.fwd1_valid ? sel_p0.data : '0;
    bus.fwd2_data  = bus.fwd2_valid ? sel_p0.data : '0;
  end
`else
  always_comb begin
    bus.fwd1_valid = 1'b0;
    bus.fwd2_valid = 1'b0;
    bus.fwd1_data  = '0;
    bus.fwd2_data  = '0;
  end
`endif

  assign bus.hazard = (dep1 && !bus.fwd1_valid) || (dep2 && !bus.fwd2_valid);

endmodule
